// File: rtl/pin_event_monitor_pkg.sv
// Shared sizing and event record for the board pin event monitor.
package pin_event_monitor_pkg;
  localparam int NUM_PINS  = 87;
  localparam int PIN_IDX_W = $clog2(NUM_PINS);

  typedef struct packed {
    logic [PIN_IDX_W-1:0] idx;
    logic                 level;
  } pin_event_t;
endpackage

// File: rtl/pin_event_monitor_if.sv
// Valid/ready event stream carrying {index, level} pin change reports.
interface pin_event_monitor_if import pin_event_monitor_pkg::*; #(
  parameter int IdxW = PIN_IDX_W
);
  logic            event_valid_o;
  logic            event_ready_i;
  logic [IdxW-1:0] event_idx_o;
  logic            event_level_o;

  modport master (output event_valid_o, event_idx_o, event_level_o, input event_ready_i);
  modport slave  (input event_valid_o, event_idx_o, event_level_o, output event_ready_i);
endinterface

// File: rtl/pin_event_monitor_filter.sv
// One pin: 2-flop synchroniser plus run-length glitch filter.
module pin_filter #(
  parameter int FilterCycles = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic change_o
);
  localparam int CntW = (FilterCycles > 1) ? $clog2(FilterCycles + 1) : 1;

  logic [1:0]      r_sync;
  logic            r_filt;
  logic [CntW-1:0] r_cnt;
  logic            w_flip;

  // Accept the new level once it has disagreed for FilterCycles samples in a row.
  assign w_flip   = (r_sync[1] != r_filt) && (r_cnt == CntW'(FilterCycles - 1));
  assign level_o  = r_filt;
  assign change_o = w_flip;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], pin_i};
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pin_event_monitor.sv
// Filters every board pin and reports each filtered level change as an
// {index, level} event, lowest pending index first.
module pin_event_monitor import pin_event_monitor_pkg::*; #(
  parameter int NumPins      = NUM_PINS,
  parameter int FilterCycles = 4,
  parameter int IdxW         = $clog2(NumPins)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumPins-1:0] pins_i,
  input  logic               enable_i,
  output logic [NumPins-1:0] level_o,
  pin_event_monitor_if.master evt
);
  logic [NumPins-1:0] w_chg, w_sel_oh, w_clr, r_pend;
  logic               w_any, w_load;
  logic [IdxW-1:0]    w_sel_idx;
  logic               r_valid, r_level;
  logic [IdxW-1:0]    r_idx;

  for (genvar g = 0; g < NumPins; g++) begin : g_pin
    pin_filter #(.FilterCycles(FilterCycles)) u_filt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pin_i   (pins_i[g]),
      .level_o (level_o[g]),
      .change_o(w_chg[g])
    );
  end

  // Descending scan so the last hit is the lowest pending index.
  always_comb begin
    w_any     = 1'b0;
    w_sel_idx = '0;
    w_sel_oh  = '0;
    for (int i = NumPins - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_any     = 1'b1;
        w_sel_idx = IdxW'(i);
        w_sel_oh  = '0;
        w_sel_oh[i] = 1'b1;
      end
    end
  end

  assign w_load = !r_valid || evt.event_ready_i;
  assign w_clr  = w_load ? w_sel_oh : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend  <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_level <= 1'b0;
    end else begin
      // A new change in the same cycle as the load re-arms the pin.
      r_pend <= enable_i ? ((r_pend & ~w_clr) | w_chg) : '0;
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_idx   <= w_sel_idx;
          r_level <= |(level_o & w_sel_oh);
        end
      end
    end
  end

  assign evt.event_valid_o = r_valid;
  assign evt.event_idx_o   = r_idx;
  assign evt.event_level_o = r_level;
endmodule

// File: tb/tb_pin_event_monitor.sv
// Directed tables, corner sequences and a randomized run against a
// windowed-history reference model of the pin event monitor.
module tb_pin_event_monitor;
  import pin_event_monitor_pkg::*;

  localparam int NP = 87;
  localparam int FC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] pins = '0;
  logic          en = 1'b0;
  logic          rdy = 1'b0;
  logic [NP-1:0] lvl;

  int total = 0;
  int bad   = 0;

  pin_event_monitor_if #(.IdxW(7)) evt ();
  assign evt.event_ready_i = rdy;

  pin_event_monitor #(.NumPins(NP), .FilterCycles(FC), .IdxW(7)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .pins_i  (pins),
    .enable_i(en),
    .level_o (lvl),
    .evt     (evt)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last FC synchronised
  // samples all disagree with it; events follow the lowest pending pin.
  logic [NP-1:0] m_d1, m_d2, m_filt, m_pend;
  logic [FC-1:0] m_win [NP];
  logic          m_valid, m_lvl;
  logic [6:0]    m_idx;

  always @(posedge clk) begin : ref_model
    logic [NP-1:0] chg, pend, filt;
    logic [FC-1:0] w;
    int            first;
    logic          v, el;
    logic [6:0]    ix;
    if (rst) begin
      m_d1 <= '0; m_d2 <= '0; m_filt <= '0; m_pend <= '0;
      m_valid <= 1'b0; m_lvl <= 1'b0; m_idx <= '0;
      for (int i = 0; i < NP; i++) m_win[i] <= '0;
    end else begin
      pend = m_pend; filt = m_filt; v = m_valid; ix = m_idx; el = m_lvl; chg = '0;
      for (int i = 0; i < NP; i++) begin
        w = {m_win[i][FC-2:0], m_d2[i]};
        m_win[i] <= w;
        if (w == {FC{~filt[i]}}) chg[i] = 1'b1;
      end
      first = -1;
      for (int i = NP - 1; i >= 0; i--) if (pend[i]) first = i;
      if (!v || rdy) begin
        v = (first >= 0);
        if (first >= 0) begin
          ix = 7'(first); el = filt[first]; pend[first] = 1'b0;
        end
      end
      m_pend  <= en ? (pend | chg) : '0;
      m_filt  <= filt ^ chg;
      m_valid <= v; m_idx <= ix; m_lvl <= el;
      m_d2 <= m_d1; m_d1 <= pins;
    end
  end

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Event capture with ready held high: each valid sample is a distinct event.
  pin_event_t ev [16];
  int         ev_cyc [16];
  int         ev_n;

  task automatic collect(int n);
    ev_n = 0;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (evt.event_valid_o) begin
        if (ev_n < 16) begin
          ev[ev_n].idx = evt.event_idx_o; ev[ev_n].level = evt.event_level_o; ev_cyc[ev_n] = c;
        end
        ev_n++;
      end
    end
  endtask

  typedef struct { logic exp_l10; logic exp_vld; logic [6:0] exp_idx; logic exp_el; } rise_vec_t;
  rise_vec_t rv [8];

  int sel [8] = '{0, 1, 2, 3, 40, 41, 85, 86};
  int n, hold_bad;

  initial begin
    rv = '{'{1'b0, 1'b0, 7'd0, 1'b0}, '{1'b0, 1'b0, 7'd0, 1'b0}, '{1'b0, 1'b0, 7'd0, 1'b0},
           '{1'b0, 1'b0, 7'd0, 1'b0}, '{1'b0, 1'b0, 7'd0, 1'b0}, '{1'b1, 1'b0, 7'd0, 1'b0},
           '{1'b1, 1'b1, 7'd10, 1'b1}, '{1'b1, 1'b0, 7'd0, 1'b0}};

    // Reset state
    rst = 1'b1; tick(); tick();
    chk("rst_level", lvl, 0);
    chk("rst_valid", evt.event_valid_o, 0);
    chk("rst_idx", evt.event_idx_o, 0);
    chk("rst_elvl", evt.event_level_o, 0);
    rst = 1'b0; en = 1'b1; rdy = 1'b1;
    tick(); tick();

    // Single rise on pin 10, edge by edge
    pins[10] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rise_level_e%0d", k + 1), lvl, rv[k].exp_l10 ? (128'(1) << 10) : 128'(0));
      chk($sformatf("rise_valid_e%0d", k + 1), evt.event_valid_o, rv[k].exp_vld);
      if (rv[k].exp_vld) begin
        chk($sformatf("rise_idx_e%0d", k + 1), evt.event_idx_o, rv[k].exp_idx);
        chk($sformatf("rise_elvl_e%0d", k + 1), evt.event_level_o, rv[k].exp_el);
      end
    end

    // Glitch: 3-cycle pulse is filtered, 4-cycle pulse passes both edges
    pins[3] = 1'b1; tick(); tick(); tick(); pins[3] = 1'b0;
    collect(15);
    chk("glitch3_events", ev_n, 0);
    chk("glitch3_level", lvl[3], 0);
    pins[3] = 1'b1; tick(); tick(); tick(); tick(); pins[3] = 1'b0;
    collect(20);
    chk("glitch4_events", ev_n, 2);
    chk("glitch4_ev0", {ev[0].idx, ev[0].level}, {7'd3, 1'b1});
    chk("glitch4_ev1", {ev[1].idx, ev[1].level}, {7'd3, 1'b0});

    // Simultaneous changes come out in index order on consecutive cycles
    pins[86] = 1'b1; pins[0] = 1'b1; pins[40] = 1'b1;
    collect(15);
    chk("simul_events", ev_n, 3);
    chk("simul_ev0", {ev[0].idx, ev[0].level}, {7'd0, 1'b1});
    chk("simul_ev1", {ev[1].idx, ev[1].level}, {7'd40, 1'b1});
    chk("simul_ev2", {ev[2].idx, ev[2].level}, {7'd86, 1'b1});
    chk("simul_first_edge", ev_cyc[0], 7);
    chk("simul_spacing", {ev_cyc[1] - ev_cyc[0], ev_cyc[2] - ev_cyc[1]}, {32'd1, 32'd1});

    // Backpressure: {5,1} held stable; the later low/high pair coalesces into
    // a single extra pending event, reported at its final level.
    rdy = 1'b0; pins[5] = 1'b1; hold_bad = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t >= 7) begin
        if (!(evt.event_valid_o && evt.event_idx_o == 7'd5 && evt.event_level_o)) hold_bad++;
      end else if (evt.event_valid_o) hold_bad++;
      if (t == 10) pins[5] = 1'b0;
      if (t == 20) pins[5] = 1'b1;
    end
    chk("bp_hold_stable", hold_bad, 0);
    rdy = 1'b1;
    collect(15);
    chk("bp_coalesced_events", ev_n, 1);
    chk("bp_coalesced_ev", {ev[0].idx, ev[0].level}, {7'd5, 1'b1});

    // Disable: level tracks, no events, none retro-reported on re-enable
    en = 1'b0; pins[7] = 1'b1;
    collect(12);
    chk("dis_events", ev_n, 0);
    chk("dis_level7", lvl[7], 1);
    en = 1'b1;
    collect(10);
    chk("reen_events", ev_n, 0);
    pins[7] = 1'b0;
    collect(12);
    chk("reen_change_events", ev_n, 1);
    chk("reen_change_ev", {ev[0].idx, ev[0].level}, {7'd7, 1'b0});

    // Mid-operation reset with an event held under backpressure
    pins = '0; pins[20] = 1'b1; rst = 1'b1; tick(); rst = 1'b0; rdy = 1'b0;
    n = 0;
    while (!evt.event_valid_o && n < 20) begin tick(); n++; end
    chk("mr_first_idx", evt.event_idx_o, 20);
    tick(); tick();
    rst = 1'b1; tick();
    chk("mr_level", lvl, 0);
    chk("mr_valid", evt.event_valid_o, 0);
    chk("mr_idx", evt.event_idx_o, 0);
    chk("mr_elvl", evt.event_level_o, 0);
    rst = 1'b0;
    n = 0;
    while (!evt.event_valid_o && n < 20) begin tick(); n++; end
    chk("mr_rereport_edges", n, 3 + FC);
    chk("mr_rereport_ev", {evt.event_idx_o, evt.event_level_o}, {7'd20, 1'b1});

    // Randomized run against the reference model
    rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < 8; j++) if ($urandom_range(5) == 0) pins[sel[j]] = ~pins[sel[j]];
      rdy = ($urandom_range(9) < 7);
      if ($urandom_range(49) == 0) en = ~en;
      rst = ($urandom_range(399) == 0);
      tick();
      chk("rnd_level", lvl, m_filt);
      chk("rnd_valid", evt.event_valid_o, m_valid);
      if (m_valid) begin
        chk("rnd_idx", evt.event_idx_o, m_idx);
        chk("rnd_elvl", evt.event_level_o, m_lvl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pin_event_monitor.md
# pin_event_monitor

Input-direction companion to the board pin map: samples every board pin as an input, synchronises and glitch-filters each one, and reports each filtered level change as an `{index, level}` event on a valid/ready stream. It sits between the pad inputs and the system's GPIO/interrupt logic, so software can observe any header pin without a dedicated peripheral.

## Interface

**Parameters**
- `NumPins`, default `sonata_pkg::NUM_PINS` (87): number of monitored pins.
- `FilterCycles`, default 4: consecutive stable synchronised cycles required before a level is accepted. Legal range is ≥1; 1 means no filtering.
- `IdxW`, default `$clog2(NumPins)` (7): event index width.

**Ports**
- `clk_i`, in, 1: system clock. The block uses this single clock only.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `pins_i`, in, `NumPins`: raw asynchronous pad levels. `pins_i[i]` is the element `i` of the pin array union.
- `enable_i`, in, 1: event generation enable.
- `level_o`, out, `NumPins`: filtered pin levels.
- `event_valid_o`, out, 1: event available.
- `event_ready_i`, in, 1: consumer accepts the event.
- `event_idx_o`, out, `IdxW`: pin index of the event.
- `event_level_o`, out, 1: filtered level of that pin when the event was loaded.

## Operation

**Per-pin pipeline**
- A 2-flop synchroniser produces `sync[i]`.
- Filter counter `cnt[i]` has width `$clog2(FilterCycles+1)`.
  - If `sync[i] == filt[i]`: `cnt` ← 0.
  - Else if `cnt == FilterCycles-1`: `filt` ← `sync`, `cnt` ← 0.
  - Else: `cnt` increments.
- `level_o` = `filt`.

**Change detection**
- Any edge that updates `filt[i]` sets `pend[i]`.
- While `enable_i` = 0, all `pend` bits are held at 0 and new changes are dropped. `filt` keeps tracking regardless of `enable_i`.

**Event register** (`event_valid_o`, `event_idx_o`, `event_level_o`)
- The register loads when it is empty, or when `event_valid_o & event_ready_i` in that cycle.
- The source is the lowest-index set `pend` bit. On load, that pin's `pend` clears and `event_level_o` ← its current `filt`.
- If nothing is pending when a handshake completes, `event_valid_o` drops.
- While `event_valid_o & !event_ready_i`, the index and level must stay stable.

**Boundary conditions**
- **Coalescing:** further changes on an already-pending pin produce no extra event. The reported level is `filt` at load time, so toggles that happen while the pin is pending and return to the original level still yield one event.
- **Set/clear collision:** if a pin's pending bit is cleared by a load and set by a new change in the same cycle, set wins and a second event follows.
- **Glitches:** a pulse shorter than `FilterCycles` synchronised cycles yields no `level_o` change and no event.
- **Index range:** the index is always `< NumPins`.
- **Fixed priority:** arbitration is fixed lowest-index priority. Starvation is acceptable because each pin holds at most one pending event.
- **Disable mid-stream:** dropping `enable_i` clears `pend` but does not cancel an event already held in the output register.

**Reset** (mid-operation included, takes effect at the next edge)
- `sync`, `filt`, `cnt`, `pend` all return to 0.
- `level_o` = 0, `event_valid_o` = 0, `event_idx_o` = 0, `event_level_o` = 0.
- After reset, pins that are high generate rising events once they pass the filter.

## Timing

- Let edge 1 be the first `clk_i` edge that samples a new `pins_i` level. Then `sync` updates at edge 2.
- `filt` / `level_o` update at edge `2+FilterCycles`, which is edge 6 at the default.
- `pend` sets at that same edge.
- `event_valid_o` rises at edge `3+FilterCycles` (edge 7 at default), provided the output register is empty.
- With `event_ready_i` held at 1, sustained throughput is one event per cycle.
- No combinational path from `event_ready_i` to any output.

## Structure

**Additions to `sonata_pkg`**
- `PIN_IDX_W = $clog2(NUM_PINS)`.
- `typedef struct packed { logic [PIN_IDX_W-1:0] idx; logic level; } pin_event_t;`

**Sub-module**
- `pin_filter`: synchroniser plus counter plus `filt` for one pin, with parameter `FilterCycles`, ports `clk_i`, `rst_i`, `pin_i`, `level_o`, `change_o`.
- Instantiated `NumPins` times in a generate loop.
- The top level holds `pend`, the priority encoder and the event register.

## Test plan

- **Single rise:** reset, `enable_i`=1, ready=1; raise `pins_i[10]` before edge 1 → `level_o[10]`=1 at edge 6; event {idx 10, level 1} valid for one cycle after edge 7.
- **Glitch:** pulse `pins_i[3]` high for 3 cycles, then a separate 4-cycle pulse → no event for the first, rise and fall events (idx 3) for the second.
- **Simultaneous changes:** raise pins 86, 0, 40 on the same cycle with ready=1 → events in order idx 0, 40, 86 on three consecutive cycles.
- **Backpressure and coalescing:** ready=0, toggle pin 5 high, low, high with 10-cycle spacing → exactly one event {5, 1} held stable until ready=1.
- **Disable:** `enable_i`=0, change pin 7 → `level_o[7]` follows, no event. Re-enable → still no event until pin 7 changes again.
- **Mid-operation reset:** reset while an event is valid with ready=0 → all outputs 0 at the next edge. High pins re-report after `3+FilterCycles` edges.
